// File: rtl/lsu_bus_master.sv
// LSU bus initiator: one request beat and one response beat per access,
// with lane alignment, byte masks and load extension.
module lsu_bus_master #(
    parameter logic [63:0] PMEM_START = 64'h8000_0000,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [63:0]       addr_i,
    input  logic [63:0]       sdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [63:0]       ldata_o,
    output logic              misalign_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [63:0]       req_wdata_o,
    output logic [7:0]        req_wmask_o,
    input  logic              rsp_valid_i,
    input  logic [63:0]       rsp_rdata_i,
    output logic              rsp_ready_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic [2:0]  off_q;
    logic [2:0]  f3_q;
    logic        mis_q;
    logic [63:0] ldata_q;

    logic        op_any;
    logic        accept;
    logic        is_st;
    logic        mis_now;
    logic [2:0]  align_m;
    logic [7:0]  bmask;
    logic [63:0] diff;
    logic [63:0] lane;
    logic [63:0] ld_ext;
    logic        unused_hi;

    assign op_any    = load_i | store_i;
    assign accept    = (state == IDLE) && op_any;
    assign is_st     = store_i & ~load_i;
    assign diff      = addr_i - PMEM_START;
    assign unused_hi = ^diff[63:ADDR_W];
    assign mis_now   = |(addr_i[2:0] & align_m);
    assign lane      = rsp_rdata_i >> {off_q, 3'b000};

    // Per-size alignment mask and byte-enable pattern before lane shift
    always_comb begin
        align_m = 3'b000;
        bmask   = 8'h01;
        unique case (funct3_i[1:0])
            2'd0: begin align_m = 3'b000; bmask = 8'h01; end
            2'd1: begin align_m = 3'b001; bmask = 8'h03; end
            2'd2: begin align_m = 3'b011; bmask = 8'h0F; end
            2'd3: begin align_m = 3'b111; bmask = 8'hFF; end
        endcase
    end

    // Pick the addressed bytes and sign/zero extend to 64 bits
    always_comb begin
        ld_ext = lane;
        unique case (f3_q[1:0])
            2'd0: ld_ext = f3_q[2] ? {56'd0, lane[7:0]}
                                   : {{56{lane[7]}}, lane[7:0]};
            2'd1: ld_ext = f3_q[2] ? {48'd0, lane[15:0]}
                                   : {{48{lane[15]}}, lane[15:0]};
            2'd2: ld_ext = f3_q[2] ? {32'd0, lane[31:0]}
                                   : {{32{lane[31]}}, lane[31:0]};
            2'd3: ld_ext = lane;
        endcase
    end

    // Access sequencing: accept, request beat, response beat, completion
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (op_any) state_nx = mis_now ? DONE : REQ;
            REQ:  if (req_ready_i) state_nx = WAIT;
            WAIT: if (rsp_valid_i) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Latch the access on accept; capture extended read data on response
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            off_q       <= 3'd0;
            f3_q        <= 3'd0;
            mis_q       <= 1'b0;
            ldata_q     <= 64'd0;
            req_we_o    <= 1'b0;
            req_addr_o  <= '0;
            req_wdata_o <= 64'd0;
            req_wmask_o <= 8'd0;
        end else if (accept) begin
            off_q       <= addr_i[2:0];
            f3_q        <= funct3_i;
            mis_q       <= mis_now;
            ldata_q     <= 64'd0;
            req_we_o    <= is_st;
            req_addr_o  <= {diff[ADDR_W-1:3], 3'b000};
            req_wdata_o <= is_st ? (sdata_i << {addr_i[2:0], 3'b000}) : 64'd0;
            req_wmask_o <= is_st ? (bmask << addr_i[2:0]) : 8'd0;
        end else if (state == WAIT && rsp_valid_i && !req_we_o) begin
            ldata_q     <= ld_ext;
        end
    end

    assign req_valid_o = (state == REQ);
    assign rsp_ready_o = (state == WAIT);
    assign done_o      = (state == DONE);
    assign misalign_o  = (state == DONE) && mis_q;
    assign ldata_o     = ldata_q;
    assign stall_o     = rst_n && op_any && (state != DONE);

endmodule

// File: tb/tb_lsu_bus_master.sv
// Testbench for lsu_bus_master: directed cases plus randomized accesses
// checked against an arithmetic model of alignment, masking and extension.
module tb_lsu_bus_master;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        load_i, store_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i, sdata_i;
    logic        stall_o, done_o, misalign_o;
    logic [63:0] ldata_o;
    logic        req_valid_o, req_ready_i, req_we_o;
    logic [31:0] req_addr_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wmask_o;
    logic        rsp_valid_i, rsp_ready_o;
    logic [63:0] rsp_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;

    // observations from the last run_op
    int          o_done_c, o_req_beats, o_rsp_beats, o_unstable, o_stall_bad;
    logic        o_mis, o_we, o_stall_acc, o_stall_done, o_done_after;
    logic [63:0] o_ld, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_mask;

    lsu_bus_master dut (
        .clock(clock), .rst_n(rst_n),
        .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .sdata_i(sdata_i),
        .stall_o(stall_o), .done_o(done_o), .ldata_o(ldata_o),
        .misalign_o(misalign_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_we_o(req_we_o), .req_addr_o(req_addr_o),
        .req_wdata_o(req_wdata_o), .req_wmask_o(req_wmask_o),
        .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i),
        .rsp_ready_o(rsp_ready_o)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3, input int off);
        return (off % nbytes(f3)) != 0;
    endfunction

    function automatic logic [63:0] exp_ld(input logic [2:0] f3, input int off,
                                           input logic [63:0] rd);
        int nb;
        logic [63:0] v, keep;
        nb = nbytes(f3);
        v  = rd >> (8 * off);
        if (nb == 8) return v;
        keep = (64'd1 << (8 * nb)) - 64'd1;
        v = v & keep;
        if (!f3[2] && v[8*nb-1]) v = v | ~keep;
        return v;
    endfunction

    function automatic logic [7:0] exp_mask(input logic [2:0] f3, input int off);
        int m;
        m = ((1 << nbytes(f3)) - 1) << off;
        return m[7:0];
    endfunction

    // ---------------- stimulus driver / responder ----------------
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] sd,
                          input logic [63:0] rd, input int rdly, input int sdly);
        int nreq, nwait;
        bit seen;
        logic [31:0] fa;
        logic [63:0] fw;
        logic [7:0]  fm;
        logic        fwe;
        nreq = 0; nwait = 0; seen = 0;
        fa = 0; fw = 0; fm = 0; fwe = 0;
        load_i = ld; store_i = st; funct3_i = f3; addr_i = a; sdata_i = sd;
        req_ready_i = 1'($urandom_range(0, 1));
        rsp_valid_i = 1'($urandom_range(0, 1));
        rsp_rdata_i = {$urandom, $urandom};
        #1;
        o_stall_acc = stall_o;
        o_done_c = -1; o_req_beats = 0; o_rsp_beats = 0;
        o_unstable = 0; o_stall_bad = 0;
        o_mis = 0; o_ld = 0; o_stall_done = 1; o_done_after = 1;
        o_addr = 0; o_we = 0; o_mask = 0; o_wdata = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (done_o) begin
                o_done_c = c;
                o_mis = misalign_o;
                o_ld = ldata_o;
                o_stall_done = stall_o;
                load_i = 0; store_i = 0;
                req_ready_i = 0; rsp_valid_i = 0;
                @(posedge clock); #1;
                o_done_after = done_o | misalign_o;
                break;
            end
            if (!stall_o) o_stall_bad++;
            if (req_valid_o) begin
                nreq++;
                if (!seen) begin
                    seen = 1;
                    fa = req_addr_o; fw = req_wdata_o;
                    fm = req_wmask_o; fwe = req_we_o;
                end else if (fa !== req_addr_o || fw !== req_wdata_o ||
                             fm !== req_wmask_o || fwe !== req_we_o) begin
                    o_unstable++;
                end
                req_ready_i = (nreq > rdly);
                if (req_ready_i) begin
                    o_req_beats++;
                    o_addr = req_addr_o; o_we = req_we_o;
                    o_mask = req_wmask_o; o_wdata = req_wdata_o;
                end
            end else begin
                req_ready_i = 1'($urandom_range(0, 1));
            end
            if (rsp_ready_o) begin
                nwait++;
                rsp_valid_i = (nwait > sdly);
                rsp_rdata_i = rsp_valid_i ? rd : {$urandom, $urandom};
                if (rsp_valid_i) o_rsp_beats++;
            end else begin
                rsp_valid_i = 1'($urandom_range(0, 1));
                rsp_rdata_i = {$urandom, $urandom};
            end
        end
        load_i = 0; store_i = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        load_i = 1;
        #1;
        n_checks++;
        if (req_valid_o !== 0 || done_o !== 0 || misalign_o !== 0 ||
            rsp_ready_o !== 0)
            $display("FAIL reset_ctrl: got v%b d%b m%b r%b want all 0",
                     req_valid_o, done_o, misalign_o, rsp_ready_o);
        else n_pass++;
        n_checks++;
        if (stall_o !== 0)
            $display("FAIL reset_stall: got %b want 0", stall_o);
        else n_pass++;
        n_checks++;
        if (ldata_o !== 0 || req_addr_o !== 0 || req_wdata_o !== 0 ||
            req_wmask_o !== 0 || req_we_o !== 0)
            $display("FAIL reset_data: ld %h a %h wd %h m %h we %b want 0",
                     ldata_o, req_addr_o, req_wdata_o, req_wmask_o, req_we_o);
        else n_pass++;
        load_i = 0;
        @(posedge clock); #1;
        rst_n = 1;
        @(posedge clock); #1;
        n_checks++;
        if (req_valid_o !== 0 || done_o !== 0 || stall_o !== 0)
            $display("FAIL reset_idle: v%b d%b s%b want 0",
                     req_valid_o, done_o, stall_o);
        else n_pass++;
    endtask

    task automatic test_lb_sign();
        run_op(1, 0, 3'b000, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 0, 0);
        n_checks++;
        if (o_done_c !== 3)
            $display("FAIL lb_latency: got %0d want 3", o_done_c);
        else n_pass++;
        n_checks++;
        if (o_addr !== 0 || o_we !== 0 || o_mask !== 0)
            $display("FAIL lb_req: a %h we %b m %h want 0/0/0",
                     o_addr, o_we, o_mask);
        else n_pass++;
        n_checks++;
        if (o_ld !== 64'hFFFF_FFFF_FFFF_FF80)
            $display("FAIL lb_ldata: got %h want FFFFFFFFFFFFFF80", o_ld);
        else n_pass++;
        n_checks++;
        if (o_stall_acc !== 1 || o_stall_done !== 0)
            $display("FAIL lb_stall: accept %b done %b want 1/0",
                     o_stall_acc, o_stall_done);
        else n_pass++;
    endtask

    task automatic test_sh_store();
        run_op(0, 1, 3'b001, 64'h8000_0006, 64'hBEEF, 0, 0, 0);
        n_checks++;
        if (o_mask !== 8'hC0 || o_we !== 1)
            $display("FAIL sh_mask: m %h we %b want C0/1", o_mask, o_we);
        else n_pass++;
        n_checks++;
        if (o_wdata !== 64'hBEEF_0000_0000_0000)
            $display("FAIL sh_wdata: got %h want BEEF000000000000", o_wdata);
        else n_pass++;
        n_checks++;
        if (o_req_beats !== 1 || o_rsp_beats !== 1 || o_done_c !== 3)
            $display("FAIL sh_beats: req %0d rsp %0d done %0d want 1/1/3",
                     o_req_beats, o_rsp_beats, o_done_c);
        else n_pass++;
    endtask

    task automatic test_misalign();
        run_op(1, 0, 3'b010, 64'h8000_0002, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        n_checks++;
        if (o_done_c !== 1 || o_mis !== 1)
            $display("FAIL mis_done: cycle %0d flag %b want 1/1",
                     o_done_c, o_mis);
        else n_pass++;
        n_checks++;
        if (o_req_beats !== 0 || o_ld !== 0)
            $display("FAIL mis_nobus: beats %0d ldata %h want 0/0",
                     o_req_beats, o_ld);
        else n_pass++;
        n_checks++;
        if (o_done_after !== 0)
            $display("FAIL mis_pulse: done after %b want 0", o_done_after);
        else n_pass++;
    endtask

    task automatic test_lwu();
        run_op(1, 0, 3'b110, 64'h8000_0004, 0, 64'hF234_5678_0000_0000, 0, 0);
        n_checks++;
        if (o_ld !== 64'h0000_0000_F234_5678 || o_addr !== 0)
            $display("FAIL lwu: ld %h a %h want 00000000F2345678/0",
                     o_ld, o_addr);
        else n_pass++;
    endtask

    task automatic test_ready_stall();
        run_op(1, 0, 3'b011, 64'h8000_0008, 0, 64'h0123_4567_89AB_CDEF, 3, 0);
        n_checks++;
        if (o_done_c !== 6)
            $display("FAIL ld_wait_latency: got %0d want 6", o_done_c);
        else n_pass++;
        n_checks++;
        if (o_unstable !== 0 || o_req_beats !== 1 || o_addr !== 32'h8)
            $display("FAIL ld_wait_req: unstable %0d beats %0d a %h want 0/1/8",
                     o_unstable, o_req_beats, o_addr);
        else n_pass++;
        n_checks++;
        if (o_ld !== 64'h0123_4567_89AB_CDEF || o_stall_bad !== 0)
            $display("FAIL ld_wait_data: ld %h stallgaps %0d",
                     o_ld, o_stall_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad;
        load_i = 1; store_i = 0; funct3_i = 3'b011; addr_i = 64'h8000_0010;
        req_ready_i = 0; rsp_valid_i = 0;
        @(posedge clock); #1;
        n_checks++;
        if (req_valid_o !== 1)
            $display("FAIL rmid_req_up: got %b want 1", req_valid_o);
        else n_pass++;
        rst_n = 0; #1;
        n_checks++;
        if (req_valid_o !== 0 || stall_o !== 0)
            $display("FAIL rmid_req_drop: v%b s%b want 0/0",
                     req_valid_o, stall_o);
        else n_pass++;
        @(posedge clock); #1;
        rst_n = 1;
        @(posedge clock); #1;
        req_ready_i = 1;
        @(posedge clock); #1;
        req_ready_i = 0;
        n_checks++;
        if (rsp_ready_o !== 1)
            $display("FAIL rmid_wait: rsp_ready %b want 1", rsp_ready_o);
        else n_pass++;
        rst_n = 0; #1;
        n_checks++;
        if (rsp_ready_o !== 0 || stall_o !== 0 || req_valid_o !== 0)
            $display("FAIL rmid_wait_drop: r%b s%b v%b want 0",
                     rsp_ready_o, stall_o, req_valid_o);
        else n_pass++;
        load_i = 0;
        rsp_valid_i = 1; rsp_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clock); #1;
        rst_n = 1;
        bad = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (done_o || req_valid_o || rsp_ready_o || ldata_o !== 0) bad++;
        end
        rsp_valid_i = 0;
        n_checks++;
        if (bad !== 0)
            $display("FAIL rmid_stale_rsp: %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_random();
        int nerr, nops;
        nerr = 0;
        nops = 150;
        for (int i = 0; i < nops; i++) begin
            int sel, off, rdly, sdly, edone;
            bit ld, st, m;
            logic [2:0]  f3;
            logic [63:0] a, sd, rd;
            logic [31:0] ea;
            sel  = $urandom_range(0, 2);
            ld   = (sel != 1);
            st   = (sel != 0);
            f3   = 3'($urandom_range(0, 7));
            a    = 64'h8000_0000 + 64'($urandom_range(0, 16'hFFFF));
            sd   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            rdly = $urandom_range(0, 3);
            sdly = $urandom_range(0, 3);
            off  = int'(a[2:0]);
            m    = exp_mis(f3, off);
            edone = m ? 1 : 3 + rdly + sdly;
            ea   = 32'((a - 64'h8000_0000) & ~64'd7);
            run_op(ld, st, f3, a, sd, rd, rdly, sdly);
            n_checks++;
            if (o_done_c !== edone || o_mis !== m) begin
                $display("FAIL rnd_done[%0d]: cycle %0d mis %b want %0d/%b",
                         i, o_done_c, o_mis, edone, m);
                nerr++;
            end else n_pass++;
            n_checks++;
            if (o_req_beats !== (m ? 0 : 1) || o_rsp_beats !== (m ? 0 : 1) ||
                o_unstable !== 0) begin
                $display("FAIL rnd_beats[%0d]: req %0d rsp %0d unstable %0d",
                         i, o_req_beats, o_rsp_beats, o_unstable);
                nerr++;
            end else n_pass++;
            n_checks++;
            if (o_stall_acc !== 1 || o_stall_bad !== 0 ||
                o_stall_done !== 0 || o_done_after !== 0) begin
                $display("FAIL rnd_stall[%0d]: acc %b gaps %0d done %b after %b",
                         i, o_stall_acc, o_stall_bad, o_stall_done, o_done_after);
                nerr++;
            end else n_pass++;
            if (m) begin
                n_checks++;
                if (o_ld !== 0) begin
                    $display("FAIL rnd_mis_ld[%0d]: got %h want 0", i, o_ld);
                    nerr++;
                end else n_pass++;
            end else begin
                n_checks++;
                if (o_addr !== ea || o_we !== !ld) begin
                    $display("FAIL rnd_req[%0d]: a %h we %b want %h/%b",
                             i, o_addr, o_we, ea, !ld);
                    nerr++;
                end else n_pass++;
                if (ld) begin
                    n_checks++;
                    if (o_mask !== 0 || o_ld !== exp_ld(f3, off, rd)) begin
                        $display("FAIL rnd_load[%0d]: m %h ld %h want 0/%h",
                                 i, o_mask, o_ld, exp_ld(f3, off, rd));
                        nerr++;
                    end else n_pass++;
                end else begin
                    n_checks++;
                    if (o_mask !== exp_mask(f3, off) ||
                        o_wdata !== (sd << (8 * off))) begin
                        $display("FAIL rnd_store[%0d]: m %h wd %h want %h/%h",
                                 i, o_mask, o_wdata, exp_mask(f3, off),
                                 sd << (8 * off));
                        nerr++;
                    end else n_pass++;
                end
            end
        end
        if (nerr != 0) $display("random section: %0d errors in %0d ops", nerr, nops);
    endtask

    initial begin
        rst_n = 0;
        load_i = 0; store_i = 0; funct3_i = 0;
        addr_i = 0; sdata_i = 0;
        req_ready_i = 0; rsp_valid_i = 0; rsp_rdata_i = 0;
        @(posedge clock); #1;
        test_reset();
        test_lb_sign();
        test_sh_store();
        test_misalign();
        test_lwu();
        test_ready_stall();
        test_reset_mid();
        test_lb_sign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
